// File: rtl/serial_digit_adder_if.sv
// Operand/result handshake bundle for serial_digit_adder.
// The producer and consumer sides are both driven from the master modport.
interface serial_digit_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: WIDTH-bit A+B+CIN, DIGIT bits per clock, with a registered ripple carry.
// All outputs are registered, and the result is published only after the final digit.
module serial_digit_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                clk,
   input logic                rst_n,
   serial_digit_adder_if.slave bus
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_digit_adder: DIGIT must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_l, b_l, acc, acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;
   logic             last;

   always_comb begin
      dsum = {1'b0, a_l[cnt*DIGIT +: DIGIT]} + {1'b0, b_l[cnt*DIGIT +: DIGIT]}
           + {{DIGIT{1'b0}}, carry};
      acc_nxt = acc;
      acc_nxt[cnt*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
   end

   assign last = (cnt == CW'(STEPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         a_l           <= '0;
         b_l           <= '0;
         acc           <= '0;
         carry         <= 1'b0;
         cnt           <= '0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.cout      <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready comes up one edge after reset release, before any accept
               if (!bus.in_ready) begin
                  bus.in_ready <= 1'b1;
               end else if (bus.in_valid) begin
                  a_l          <= bus.a;
                  b_l          <= bus.b;
                  carry        <= bus.cin;
                  cnt          <= '0;
                  acc          <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= dsum[DIGIT];
               if (last) begin
                  bus.sum       <= acc_nxt;
                  bus.cout      <= dsum[DIGIT];
                  // top digit's MSB is the sum MSB, so this is carry-in vs carry-out of bit WIDTH-1
                  bus.ovf       <= (a_l[WIDTH-1] == b_l[WIDTH-1]) && (dsum[DIGIT-1] != a_l[WIDTH-1]);
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench: a 1-bit instance as full adder plus 16-bit instances at DIGIT 1,2,4,8,16 sharing
// one stimulus bus, checked against a plain-arithmetic model.
module tb_serial_digit_adder;
   localparam int ND = 5;
   localparam int DG [ND] = '{1, 2, 4, 8, 16};
   localparam int K4 = 2;  // index of the DIGIT=4 instance

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        iv, ordy, ci;
   logic [15:0] a, b;
   logic [ND-1:0]       irdy, ovld, co, ov;
   logic [ND-1:0][15:0] sm;

   int checks = 0;
   int passes = 0;

   generate
      for (genvar g = 0; g < ND; g++) begin : g_dut
         serial_digit_adder_if #(.WIDTH(16)) bus ();
         assign bus.in_valid  = iv;
         assign bus.a         = a;
         assign bus.b         = b;
         assign bus.cin       = ci;
         assign bus.out_ready = ordy;
         assign irdy[g] = bus.in_ready;
         assign ovld[g] = bus.out_valid;
         assign sm[g]   = bus.sum;
         assign co[g]   = bus.cout;
         assign ov[g]   = bus.ovf;
         serial_digit_adder #(.WIDTH(16), .DIGIT(DG[g])) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
         );
      end
   endgenerate

   serial_digit_adder_if #(.WIDTH(1)) b1 ();
   serial_digit_adder #(.WIDTH(1), .DIGIT(1)) dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b1)
   );

   // {ovf, cout, sum}: unsigned sum for sum/cout, signed range test for overflow
   function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
      int u, s, sx, sy;
      u  = int'(x) + int'(y) + int'(c);
      sx = $signed(x);
      sy = $signed(y);
      s  = sx + sy + int'(c);
      return {(s > 32767) || (s < -32768), u[16], u[15:0]};
   endfunction

   function automatic logic [2:0] model1(input logic x, input logic y, input logic c);
      int u, s;
      u = int'(x) + int'(y) + int'(c);
      s = int'(c) - int'(x) - int'(y);
      return {(s > 0) || (s < -1), u[1], u[0]};
   endfunction

   task automatic step;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
      else passes++;
   endtask

   task automatic drain;
      int n;
      ordy = 1'b1;
      iv   = 1'b0;
      n = 0;
      while (irdy != '1 && n < 40) begin
         step;
         n++;
      end
      checks++;
      if (irdy != '1) $display("FAIL drain_timeout: got in_ready %b want %b", irdy, {ND{1'b1}});
      else passes++;
   endtask

   task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [17:0] e;
      int n;
      e    = model16(x, y, c);
      ordy = 1'b1;
      iv = 1'b1; a = x; b = y; ci = c;
      step;
      iv = 1'b0; a = ~x; b = ~y; ci = ~c;
      n = 0;
      while (!ovld[K4] && n < 20) begin
         step;
         n++;
      end
      checks++;
      if (n != 4) $display("FAIL %s_latency: got %0d edges want 4", name, n);
      else passes++;
      checks++;
      if ({ov[K4], co[K4], sm[K4]} !== e) $display("FAIL %s_d4: got %h want %h", name, {ov[K4], co[K4], sm[K4]}, e);
      else passes++;
      drain;
      for (int k = 0; k < ND; k++) begin
         checks++;
         if ({ov[k], co[k], sm[k]} !== e)
            $display("FAIL %s_digit%0d: got %h want %h", name, DG[k], {ov[k], co[k], sm[k]}, e);
         else passes++;
      end
   endtask

   task automatic test_reset;
      repeat (2) step;
      chk("reset_in_ready", {irdy, b1.in_ready}, '0);
      chk("reset_out_valid", {ovld, b1.out_valid}, '0);
      chk("reset_sum", {sm, b1.sum}, '0);
      chk("reset_flags", {co, ov, b1.cout, b1.ovf}, '0);
      rst_n = 1'b1;
      chk("reset_release_ready", {irdy, b1.in_ready}, '0);
      step;
      chk("first_edge_ready", {irdy, b1.in_ready}, {(ND + 1){1'b1}});
   endtask

   task automatic test_full_adder;
      logic [2:0] e;
      b1.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("fa_in_ready", b1.in_ready, 1);
         b1.in_valid = 1'b1;
         b1.a = i[2]; b1.b = i[1]; b1.cin = i[0];
         e = model1(i[2], i[1], i[0]);
         step;
         b1.in_valid = 1'b0;
         chk("fa_no_early_valid", b1.out_valid, 0);
         step;
         chk("fa_out_valid", b1.out_valid, 1);
         chk("fa_result", {b1.ovf, b1.cout, b1.sum}, e);
         step;
      end
   endtask

   task automatic test_carry_chain;
      run_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0);
   endtask

   task automatic test_overflow;
      run_op("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0);
      run_op("8000_plus_8000_c", 16'h8000, 16'h8000, 1'b1);
   endtask

   task automatic test_backpressure;
      int n;
      ordy = 1'b0;
      iv = 1'b1; a = 16'h1234; b = 16'h4321; ci = 1'b1;
      step;
      iv = 1'b0;
      n = 0;
      while (!ovld[K4] && n < 20) begin
         step;
         n++;
      end
      chk("bp_latency", n, 4);
      for (int i = 0; i < 10; i++) begin
         iv = 1'b1; a = 16'h0F0F + 16'(i); b = 16'h7777; ci = 1'b0;
         chk("bp_out_valid", ovld[K4], 1);
         chk("bp_in_ready", irdy[K4], 0);
         chk("bp_sum_stable", {ov[K4], co[K4], sm[K4]}, {2'b00, 16'h5556});
         step;
      end
      iv = 1'b0;
      ordy = 1'b1;
      step;
      chk("bp_release_ready", {irdy[K4], ovld[K4]}, 2'b10);
      drain;
      for (int k = 0; k < ND; k++)
         chk("bp_no_second_accept", {ov[k], co[k], sm[k]}, {2'b00, 16'h5556});
   endtask

   task automatic test_reset_midop;
      ordy = 1'b1;
      iv = 1'b1; a = 16'hAAAA; b = 16'h5555; ci = 1'b0;
      step;
      iv = 1'b0;
      repeat (2) step;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", ovld, '0);
      chk("rst_async_ready", irdy, '0);
      chk("rst_async_result", {ov, co, sm}, '0);
      step;
      rst_n = 1'b1;
      step;
      chk("rst_recover", {irdy, ovld}, {{ND{1'b1}}, {ND{1'b0}}});
      run_op("after_reset_3_4", 16'h0003, 16'h0004, 1'b0);
   endtask

   task automatic test_back_to_back;
      int          last_acc [ND];
      int          got      [ND];
      logic        pend     [ND];
      logic [17:0] expv     [ND];
      int          cyc;
      for (int k = 0; k < ND; k++) begin
         last_acc[k] = -1; got[k] = 0; pend[k] = 1'b0; expv[k] = '0;
      end
      iv = 1'b1;
      ordy = 1'b1;
      cyc = 0;
      while (cyc < 25000 && got[0] < 1000) begin
         for (int k = 0; k < ND; k++) begin
            if (ovld[k]) begin
               checks++;
               if (!pend[k] || {ov[k], co[k], sm[k]} !== expv[k])
                  $display("FAIL b2b_result_digit%0d: got %h want %h", DG[k], {ov[k], co[k], sm[k]}, expv[k]);
               else passes++;
               pend[k] = 1'b0;
               got[k]++;
            end
         end
         a  = 16'($urandom);
         b  = 16'($urandom);
         ci = 1'($urandom);
         for (int k = 0; k < ND; k++) begin
            if (irdy[k]) begin
               expv[k] = model16(a, b, ci);
               pend[k] = 1'b1;
               if (last_acc[k] >= 0) begin
                  checks++;
                  if (cyc - last_acc[k] != 16 / DG[k] + 2)
                     $display("FAIL b2b_spacing_digit%0d: got %0d want %0d", DG[k], cyc - last_acc[k], 16 / DG[k] + 2);
                  else passes++;
               end
               last_acc[k] = cyc;
            end
         end
         step;
         cyc++;
      end
      iv = 1'b0;
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] < 1000) $display("FAIL b2b_count_digit%0d: got %0d want >=1000", DG[k], got[k]);
         else passes++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ci = 1'b0;
      b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
      test_reset;
      test_full_adder;
      test_carry_chain;
      test_overflow;
      test_backpressure;
      test_reset_midop;
      test_back_to_back;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
